// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the instruction-fetch port, the data port and the shared memory
//   port of mem_port_arbiter.
//
//   modport slave  : the arbiter's view (requests and MemRData in; grants,
//                    responses, memory strobes and Stall out).
//   modport master : the environment's view (CPU pipeline plus memory model),
//                    the exact mirror of slave.
//
//   Signal groups:
//     fetch  : IReq, IAddr -> IGnt, IValid, IRData
//     data   : DReq, DWrite, DAddr, DWData, DBHW, DExtendSign
//              -> DGnt, DValid, DErr, DRData
//     memory : MemAddr, MemWData, MemRead, MemWrite, MemBHW, MemExtendSign
//              <- MemRData (valid one cycle after MemRead)
//     Stall  : pipeline freeze while any request waits
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
  // Fetch port
  logic        IReq;
  logic [31:0] IAddr;
  logic        IGnt;
  logic        IValid;
  logic [31:0] IRData;

  // Data port
  logic        DReq;
  logic        DWrite;
  logic [31:0] DAddr;
  logic [31:0] DWData;
  logic [1:0]  DBHW;
  logic        DExtendSign;
  logic        DGnt;
  logic        DValid;
  logic        DErr;
  logic [31:0] DRData;

  // Shared memory port
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemBHW;
  logic        MemExtendSign;
  logic [31:0] MemRData;

  logic        Stall;

  modport slave (
    input  IReq, IAddr,
    input  DReq, DWrite, DAddr, DWData, DBHW, DExtendSign,
    input  MemRData,
    output IGnt, IValid, IRData,
    output DGnt, DValid, DErr, DRData,
    output MemAddr, MemWData, MemRead, MemWrite, MemBHW, MemExtendSign,
    output Stall
  );

  modport master (
    output IReq, IAddr,
    output DReq, DWrite, DAddr, DWData, DBHW, DExtendSign,
    output MemRData,
    input  IGnt, IValid, IRData,
    input  DGnt, DValid, DErr, DRData,
    input  MemAddr, MemWData, MemRead, MemWrite, MemBHW, MemExtendSign,
    input  Stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-cycle memory port between an instruction-fetch requester
//   and a data (load/store) requester. Grants and memory strobes are
//   combinational in the accept cycle; the response (Valid + RData) appears
//   exactly one cycle later, so back-to-back accesses run one per cycle.
//
//   Misaligned data accesses (word not 4-aligned, half not 2-aligned, size 3)
//   are granted without touching memory and complete next cycle with DErr=1.
//
//   Arbitration when both sides request:
//     default                  : data wins, unless the fetch side has been
//                                denied STARVE_LIMIT consecutive cycles.
//     MEM_PORT_ARBITER_RR_EN   : a 1-bit pointer alternates the winner after
//                                each contested grant (starvation counter
//                                not built).
//
//   Parameters : STARVE_LIMIT (1..15)
//   Ports      : Clk   - clock, rising edge
//                Reset - asynchronous, active-low
//                bus   - mem_port_arbiter_if.slave (fetch, data, memory, Stall)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  mem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_PEND = 2'd1,   // fetch response due this cycle
    D_PEND = 2'd2    // data response due this cycle
  } state_t;

  state_t state, state_next;
  logic   d_store_q, d_store_next;   // pending data access was a store
  logic   d_err_q,   d_err_next;     // pending data access was misaligned

  logic   misaligned;
  logic   contested;
  logic   pick_d;
  logic   grant_i;
  logic   grant_d;

  assign misaligned = (bus.DBHW == 2'd3)
                    | ((bus.DBHW == 2'd2) & (|bus.DAddr[1:0]))
                    | ((bus.DBHW == 2'd1) & bus.DAddr[0]);

  assign contested = bus.IReq & bus.DReq;

`ifdef MEM_PORT_ARBITER_RR_EN
  logic rr_d_first;   // 1: data side wins the next contested cycle

  assign pick_d = bus.DReq & ~(contested & ~rr_d_first);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rr_d_first <= 1'b1;
    end else if (contested) begin
      // A contested cycle always produces a grant while out of reset.
      rr_d_first <= ~rr_d_first;
    end
  end
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;   // consecutive cycles IReq was denied

  assign pick_d = bus.DReq & ~(contested & (starve_cnt >= STARVE_MAX));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      starve_cnt <= '0;
    end else if (grant_i || !bus.IReq) begin
      starve_cnt <= '0;
    end else if (starve_cnt != 4'hF) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  // Grants are gated by Reset so nothing is accepted while it is held low.
  assign grant_d = Reset & pick_d;
  assign grant_i = Reset & bus.IReq & ~pick_d;

  // State register. The response flags travel with the state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      d_store_q <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples the pre-edge values, independent of statement order.
      state     <= state_next;
      d_store_q <= d_store_next;
      d_err_q   <= d_err_next;
    end
  end

  // Next state, grants, memory strobes and responses.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next        = IDLE;
    d_store_next      = 1'b0;
    d_err_next        = 1'b0;
    bus.IGnt          = grant_i;
    bus.DGnt          = grant_d;
    bus.MemAddr       = '0;
    bus.MemWData      = '0;
    bus.MemRead       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.MemBHW        = 2'd0;
    bus.MemExtendSign = 1'b0;

    if (grant_i) begin
      state_next        = I_PEND;
      bus.MemAddr       = bus.IAddr;
      bus.MemRead       = 1'b1;
      bus.MemBHW        = 2'd2;
    end else if (grant_d) begin
      state_next        = D_PEND;
      d_store_next      = bus.DWrite;
      d_err_next        = misaligned;
      bus.MemAddr       = bus.DAddr;
      bus.MemWData      = bus.DWData;
      bus.MemBHW        = bus.DBHW;
      bus.MemExtendSign = bus.DExtendSign;
      // Misaligned accesses are accepted but never reach memory.
      bus.MemRead       = ~misaligned & ~bus.DWrite;
      bus.MemWrite      = ~misaligned &  bus.DWrite;
    end

    bus.IValid = (state == I_PEND);
    bus.IRData = bus.IValid ? bus.MemRData : '0;
    bus.DValid = (state == D_PEND);
    bus.DErr   = bus.DValid & d_err_q;
    bus.DRData = (bus.DValid & ~d_store_q & ~d_err_q) ? bus.MemRData : '0;
  end

  assign bus.Stall = (bus.IReq & ~grant_i) | (bus.DReq & ~grant_d);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, consecutive denied IReq cycles before instruction side is forced to win (range 1..15).
REQ-002 SHALL have ports (name  direction  width  meaning):
- Clk  in  1  single clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IReq  in  1  instruction-fetch read request.
- IAddr  in  32  fetch byte address.
- IGnt  out  1  fetch request accepted this cycle.
- IValid  out  1  fetch data valid.
- IRData  out  32  fetch data.
- DReq  in  1  data request.
- DWrite  in  1  1=store, 0=load.
- DAddr  in  32  data byte address.
- DWData  in  32  store data.
- DBHW  in  2  size: 0=byte, 1=half, 2=word.
- DExtendSign  in  1  load sign-extension select.
- DGnt  out  1  data request accepted this cycle.
- DValid  out  1  load data valid, or store/error completion.
- DErr  out  1  misaligned access; qualifies DValid.
- DRData  out  32  load data.
- MemAddr  out  32  shared memory address.
- MemWData  out  32  shared memory write data.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- MemBHW  out  2  memory access size.
- MemExtendSign  out  1  memory sign-extension select.
- MemRData  in  32  memory read data, valid one cycle after MemRead.
- Stall  out  1  pipeline freeze: (IReq & ~IGnt) | (DReq & ~DGnt).

Function
REQ-003 SHALL grant at most one of IGnt/DGnt per cycle; grant and Mem* strobes are combinational in the accept cycle.
REQ-004 SHALL require each requester to hold Req and its payload stable until granted; a change before grant is undefined.
REQ-005 SHALL drive fetch accesses as MemRead=1, MemBHW=2, MemExtendSign=0, MemAddr=IAddr.
REQ-006 SHALL drive data accesses from DAddr, DWData, DBHW, DExtendSign; MemRead=~DWrite, MemWrite=DWrite.
REQ-007 SHALL hold MemRead=MemWrite=0 in any cycle with no grant.
REQ-008 SHALL use FSM states IDLE, I_PEND, D_PEND, where *_PEND means a response is due next cycle. Any grant enters the matching PEND state; a cycle with no grant returns to IDLE.
REQ-009 SHALL accept a new grant in I_PEND/D_PEND, giving one access per cycle back-to-back.
REQ-010 SHALL assert IValid (IRData=MemRData) or DValid (DRData=MemRData; 0 for a store) exactly one cycle after the grant.
REQ-011 SHALL give priority to D when both request, unless the starvation counter has reached STARVE_LIMIT.
REQ-012 SHALL count consecutive cycles with IReq=1 and IGnt=0 in a 4-bit saturating counter, cleared on IGnt or when IReq=0.
REQ-013 SHALL detect misalignment as DBHW=2 with DAddr[1:0]!=0, or DBHW=1 with DAddr[0]=1.
REQ-014 SHALL, on a misaligned access, grant it (DGnt=1), issue no Mem strobe, and assert DValid=1, DErr=1, DRData=0 the next cycle.
REQ-015 SHALL treat DBHW=3 as misaligned.
REQ-016 SHALL hold DErr=0 whenever DValid=0 or the access is aligned.

Reset
REQ-017 SHALL, while Reset=0, force IDLE, counter=0, round-robin pointer=D-first, and IValid=DValid=DErr=0, IRData=DRData=0, with IGnt=DGnt=MemRead=MemWrite=0.
REQ-018 SHALL discard an access granted in the cycle reset asserts; no Valid is produced for it after release.
REQ-019 SHALL allow grants in the first rising edge cycle after Reset deasserts.

Configuration
REQ-020 SHALL recognise macro MEM_PORT_ARBITER_RR_EN. When defined, simultaneous requests alternate by a 1-bit pointer that toggles after each contested grant, and the starvation counter is not compiled. When undefined, REQ-011 and REQ-012 apply.

Verification
REQ-021 SHALL cover: IReq with IAddr=0x40, MemRData=0x2402000A -> IGnt same cycle, next cycle IValid=1, IRData=0x2402000A.
REQ-022 SHALL cover: store DAddr=0x100, DWData=0xDEADBEEF, DBHW=2 -> MemWrite=1, MemAddr=0x100 once; next cycle DValid=1, DErr=0.
REQ-023 SHALL cover: IReq and DReq held 6 cycles, STARVE_LIMIT=4, macro undefined -> grants D,D,D,D,I,D; Stall=1 every cycle.
REQ-024 SHALL cover: same stimulus with MEM_PORT_ARBITER_RR_EN -> grants D,I,D,I,D,I.
REQ-025 SHALL cover: load DAddr=0x102, DBHW=2 -> no MemRead; next cycle DValid=1, DErr=1, DRData=0.
REQ-026 SHALL cover: Reset low in the cycle after an IGnt -> IValid stays 0, state IDLE, and the next IReq is granted on the first cycle after release.
